// File: rtl/decode_queue.sv
// Decode stage with an integrated circular instruction queue: buffers fetched
// instructions, decodes the head combinationally, issues under backpressure.
module decode_queue #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush,
  input  logic             fetch_valid,
  input  logic [31:0]      fetch_inst,
  input  logic [31:0]      fetch_pc,
  input  logic             fetch_pred,
  output logic             fetch_ready,
  input  logic             RS_full,
  input  logic             LSB_full,
  input  logic             RoB_full,
  input  logic             RoB_stall,
  output logic             issue_valid,
  output logic [6:0]       opcode,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [2:0]       funct3,
  output logic             funct7,
  output logic [31:0]      imm,
  output logic [31:0]      issue_pc,
  output logic             issue_pred,
  output logic             need_LSB,
  output logic             illegal,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [31:0] inst_q [DEPTH];
  logic [31:0] pc_q   [DEPTH];
  logic        pred_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0] head_inst;
  logic        is_jal;
  logic        is_branch;
  logic        stall;
  logic        enq;
  logic        fire;

  // Head entry and field extraction
  assign head_inst  = inst_q[head_q];
  assign issue_pc   = pc_q[head_q];
  assign issue_pred = pred_q[head_q];

  assign opcode = head_inst[6:0];
  assign rd     = head_inst[11:7];
  assign funct3 = head_inst[14:12];
  assign rs1    = head_inst[19:15];
  assign rs2    = head_inst[24:20];
  assign funct7 = head_inst[30];

  assign is_jal    = (opcode == OP_JAL);
  assign is_branch = (opcode == OP_BRANCH);
  assign need_LSB  = (opcode == OP_LOAD) || (opcode == OP_STORE);

  // NOTE: every variable written in a combinational block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC: imm = {head_inst[31:12], 12'b0};
      OP_JAL:    imm = {{12{head_inst[31]}}, head_inst[19:12], head_inst[20],
                        head_inst[30:21], 1'b0};
      OP_BRANCH: imm = {{20{head_inst[31]}}, head_inst[7], head_inst[30:25],
                        head_inst[11:8], 1'b0};
      OP_STORE:  imm = {{21{head_inst[31]}}, head_inst[30:25], head_inst[11:7]};
      OP_IMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101)
          imm = {27'b0, head_inst[24:20]};
        else
          imm = {{21{head_inst[31]}}, head_inst[30:20]};
      end
      OP_LOAD, OP_JALR: imm = {{21{head_inst[31]}}, head_inst[30:20]};
      OP_R:      imm = '0;
      default:   illegal = 1'b1;
    endcase
  end

  assign stall = RoB_full || RoB_stall || (need_LSB && LSB_full) || (!need_LSB && RS_full);

  assign issue_valid    = (count_q != '0) && !stall && !flush && rdy_in;
  assign fire           = issue_valid;
  assign redirect_valid = fire && (is_jal || (is_branch && issue_pred));
  assign redirect_pc    = issue_pc + imm;

  // A full queue refuses input even if the head issues this cycle.
  assign fetch_ready = !rst_in && (count_q != CNT_W'(DEPTH));
  assign enq         = fetch_valid && fetch_ready && rdy_in && !flush && !redirect_valid;

  assign count = count_q;

  // Flush outranks redirect; both are frozen along with everything else while rdy_in is low.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rdy_in) begin
      if (flush) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else if (redirect_valid) begin
        head_d  = tail_q;
        count_d = '0;
      end else begin
        if (enq)  tail_d = tail_q + PTR_W'(1);
        if (fire) head_d = head_q + PTR_W'(1);
        count_d = count_q + CNT_W'(enq) - CNT_W'(fire);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: the entry storage has no reset; count_q alone defines which slots
  // are live, so resetting the array would only add reset fan-out.
  always_ff @(posedge clk_in) begin
    if (enq) begin
      inst_q[tail_q] <= fetch_inst;
      pc_q[tail_q]   <= fetch_pc;
      pred_q[tail_q] <= fetch_pred;
    end
  end

endmodule
